// File: rtl/rv32i_vec_pkg.sv
// Shared types and constants for the vector reroute stage: lane width defaults,
// reroute code values, output-register states and the held-entry layout.
package rv32i_vec_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int LANES_DEFAULT = 4;

    typedef logic [XLEN_DEFAULT-1:0] lane_t;

    localparam logic [2:0] INS_L0 = 3'd0;
    localparam logic [2:0] INS_L1 = 3'd1;
    localparam logic [2:0] INS_L2 = 3'd2;
    localparam logic [2:0] INS_L3 = 3'd3;
    localparam logic [2:0] EXT_L0 = 3'd4;
    localparam logic [2:0] EXT_L1 = 3'd5;
    localparam logic [2:0] EXT_L2 = 3'd6;
    localparam logic [2:0] EXT_L3 = 3'd7;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    typedef struct packed {
        lane_t [LANES_DEFAULT-1:0] vec;
        logic  [4:0]               rd;
        logic                      wb;
    } entry_t;

endpackage

// File: rtl/vector_lane_mux.sv
// Combinational lane reroute: insert the scalar into one lane, or extract one
// lane into lane 0, or pass the vector through untouched.
module vector_lane_mux
    import rv32i_vec_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int LANES = LANES_DEFAULT
) (
    input  logic                  select,
    input  logic [2:0]            code,
    input  logic [XLEN-1:0]       scalar_in,
    input  logic [LANES*XLEN-1:0] vector_in,
    output logic [LANES*XLEN-1:0] vector_out,
    output logic                  scalar_wb
);

    logic [1:0]      laneSel;
    logic [XLEN-1:0] extracted;

    assign laneSel = code[1:0];

    // Codes at or above EXT_L0 extract; lower codes insert into lane laneSel.
    always_comb begin
        extracted  = '0;
        vector_out = vector_in;
        scalar_wb  = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (laneSel == 2'(l)) begin
                extracted = vector_in[l*XLEN +: XLEN];
            end
        end
        if (select) begin
            if (code >= EXT_L0) begin
                vector_out[XLEN-1:0] = extracted;
                scalar_wb            = 1'b1;
            end else begin
                for (int l = 0; l < LANES; l++) begin
                    if (laneSel == 2'(l)) begin
                        vector_out[l*XLEN +: XLEN] = scalar_in;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/vector_reroute_stage.sv
// Registered vector reroute stage with valid/ready handshake and flush.
// Define REROUTE_SKID_EN to add a one-entry skid buffer with registered in_ready.
module vector_reroute_stage
    import rv32i_vec_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int LANES = LANES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  rerouting_select,
    input  logic [2:0]            rerouting_code,
    input  logic [XLEN-1:0]       scalar_in,
    input  logic [LANES*XLEN-1:0] vector_in,
    input  logic [4:0]            rd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*XLEN-1:0] vector_out,
    output logic [XLEN-1:0]       scalar_out,
    output logic [4:0]            rd_out,
    output logic                  scalar_wb
);

    localparam int VW = LANES*XLEN;

    out_state_t    state_q, state_d;
    logic [VW-1:0] muxVec;
    logic          muxWb;
    logic [VW-1:0] outVec_q, outVec_d;
    logic [4:0]    outRd_q, outRd_d;
    logic          outWb_q, outWb_d;
    logic          inXfer, outXfer;

    vector_lane_mux #(
        .XLEN  (XLEN),
        .LANES (LANES)
    ) u_lane_mux (
        .select     (rerouting_select),
        .code       (rerouting_code),
        .scalar_in  (scalar_in),
        .vector_in  (vector_in),
        .vector_out (muxVec),
        .scalar_wb  (muxWb)
    );

    assign out_valid  = (state_q == FULL);
    assign outXfer    = out_valid && out_ready;
    assign inXfer     = in_valid && in_ready;
    assign vector_out = outVec_q;
    assign scalar_out = outVec_q[XLEN-1:0];
    assign rd_out     = outRd_q;
    assign scalar_wb  = outWb_q;

`ifdef REROUTE_SKID_EN
    logic          skidValid_q, skidValid_d;
    logic [VW-1:0] skidVec_q, skidVec_d;
    logic [4:0]    skidRd_q, skidRd_d;
    logic          skidWb_q, skidWb_d;
    logic          inReady_q, inReady_d;

    assign in_ready = inReady_q && !rst;

    // The skid can only be occupied while the output register is FULL, so an
    // output transfer always refills from the skid before taking new input.
    always_comb begin
        state_d     = state_q;
        outVec_d    = outVec_q;
        outRd_d     = outRd_q;
        outWb_d     = outWb_q;
        skidValid_d = skidValid_q;
        skidVec_d   = skidVec_q;
        skidRd_d    = skidRd_q;
        skidWb_d    = skidWb_q;
        if (flush) begin
            state_d     = EMPTY;
            skidValid_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (inXfer) begin
                        state_d  = FULL;
                        outVec_d = muxVec;
                        outRd_d  = rd_in;
                        outWb_d  = muxWb;
                    end
                end
                FULL: begin
                    if (outXfer) begin
                        if (skidValid_q) begin
                            outVec_d    = skidVec_q;
                            outRd_d     = skidRd_q;
                            outWb_d     = skidWb_q;
                            skidValid_d = 1'b0;
                        end else if (inXfer) begin
                            outVec_d = muxVec;
                            outRd_d  = rd_in;
                            outWb_d  = muxWb;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else if (inXfer) begin
                        skidValid_d = 1'b1;
                        skidVec_d   = muxVec;
                        skidRd_d    = rd_in;
                        skidWb_d    = muxWb;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        inReady_d = !skidValid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skidValid_q <= 1'b0;
            skidVec_q   <= '0;
            skidRd_q    <= '0;
            skidWb_q    <= 1'b0;
            inReady_q   <= 1'b1;
        end else begin
            skidValid_q <= skidValid_d;
            skidVec_q   <= skidVec_d;
            skidRd_q    <= skidRd_d;
            skidWb_q    <= skidWb_d;
            inReady_q   <= inReady_d;
        end
    end
`else
    assign in_ready = !rst && (!out_valid || out_ready);

    // Without a skid, new input is only accepted when the output slot frees up.
    always_comb begin
        state_d  = state_q;
        outVec_d = outVec_q;
        outRd_d  = outRd_q;
        outWb_d  = outWb_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (inXfer) begin
            state_d  = FULL;
            outVec_d = muxVec;
            outRd_d  = rd_in;
            outWb_d  = muxWb;
        end else if (outXfer) begin
            state_d = EMPTY;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            outVec_q <= '0;
            outRd_q  <= '0;
            outWb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            outVec_q <= outVec_d;
            outRd_q  <= outRd_d;
            outWb_q  <= outWb_d;
        end
    end

endmodule
